// File: rtl/call_stack_if.sv
// Control/data bundle between the control unit and the return-address stack.
// The control unit is the master; the stack is the slave.
interface call_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic             inc;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    modport master (
        output push, pop, inc, din,
        input  top, count, empty, full, ovf, unf
    );

    modport slave (
        input  push, pop, inc, din,
        output top, count, empty, full, ovf, unf
    );
endinterface

// File: rtl/call_stack.sv
// Return-address stack: JMS pushes, BRB pops, inc bumps the top entry in place.
// Overflow/underflow attempts are refused and latched in sticky flags.
module call_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        clr,
    call_stack_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_REPLACE,
        OP_PUSH,
        OP_POP,
        OP_INC,
        OP_OVF,
        OP_UNF
    } op_e;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    op_e              op;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] top_val;
    logic             is_empty;
    logic             is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign top_idx  = AW'(count_q - CW'(1));
    assign top_val  = is_empty ? '0 : mem_q[top_idx];

    // Operation priority: push&pop, push, pop, inc; inc is dropped if push or pop is present.
    always_comb begin
        op = OP_HOLD;
        if (bus.push && bus.pop) begin
            op = is_empty ? OP_PUSH : OP_REPLACE;
        end else if (bus.push) begin
            op = is_full ? OP_OVF : OP_PUSH;
        end else if (bus.pop) begin
            op = is_empty ? OP_UNF : OP_POP;
        end else if (bus.inc) begin
            op = is_empty ? OP_UNF : OP_INC;
        end
    end

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_idx  = top_idx;
        wr_data = bus.din;
        unique case (op)
            OP_REPLACE: begin
                wr_en = 1'b1;
            end
            OP_PUSH: begin
                wr_en   = 1'b1;
                wr_idx  = AW'(count_q);
                count_d = count_q + CW'(1);
            end
            OP_POP: begin
                count_d = count_q - CW'(1);
            end
            OP_INC: begin
                wr_en   = 1'b1;
                wr_data = top_val + WIDTH'(1);
            end
            OP_OVF:  ovf_d = 1'b1;
            OP_UNF:  unf_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry storage is deliberately not cleared by clr.
    always_ff @(posedge clk) begin
        if (!clr && wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign bus.top   = top_val;
    assign bus.count = count_q;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule
